solver_loader: RTL and testbench

SOLVER_LOADER -- requirements
Module: solver_loader

---
 rtl/solver_loader.sv | 167 ++++++++++++++++
 tb/tb_solver_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/solver_loader.sv
// solver_loader
// Sequences one solver job at a time: accepts a job header, pulses the
// solver reset, writes the limb count and iteration limit, streams the
// operand limbs into the solver, pulses start, waits for the solver to
// finish and holds the iteration count until the consumer takes it.
//
// Ports
//   clock, reset              rising-edge clock, asynchronous active-low reset
//   job_valid/job_ready       job header handshake (job_num_limbs, job_iter_lim)
//   in_valid/in_ready         limb-pair stream (in_real, in_imag), index 0..N-1
//   solver_reset              one-cycle active-high solver reset
//   wr_real_en/wr_imag_en     limb writes at wr_index with real_data/imag_data
//   wr_num_limbs_en           limb-count write (num_limbs_data)
//   wr_iter_lim_en            iteration-limit write (iter_lim_data)
//   start                     one-cycle solver start pulse
//   solver_out_ready          solver done, solver_iterations valid
//   result_valid/result_ready result handshake (result_iterations)
//   busy                      high whenever a job is in progress
module solver_loader #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_SIZE_BITS  = 8,
    parameter int ITER_BITS       = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [LIMB_INDEX_BITS-1:0] job_num_limbs,
    input  logic [ITER_BITS-1:0]       job_iter_lim,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LIMB_SIZE_BITS-1:0]  in_real,
    input  logic [LIMB_SIZE_BITS-1:0]  in_imag,
    output logic                       solver_reset,
    output logic                       wr_real_en,
    output logic                       wr_imag_en,
    output logic [LIMB_INDEX_BITS-1:0] wr_index,
    output logic [LIMB_SIZE_BITS-1:0]  real_data,
    output logic [LIMB_SIZE_BITS-1:0]  imag_data,
    output logic                       wr_num_limbs_en,
    output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
    output logic                       wr_iter_lim_en,
    output logic [ITER_BITS-1:0]       iter_lim_data,
    output logic                       start,
    input  logic                       solver_out_ready,
    input  logic [ITER_BITS-1:0]       solver_iterations,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [ITER_BITS-1:0]       result_iterations,
    output logic                       busy
);

    typedef enum logic [2:0] {
        IDLE, SRST, CFG, LOAD, START, GAP, WAIT, RESULT
    } state_t;

    localparam logic [LIMB_INDEX_BITS-1:0] ONE_IDX = LIMB_INDEX_BITS'(1);

    state_t                     state_q, state_d;
    logic [LIMB_INDEX_BITS-1:0] cnt_q, cnt_d;
    logic [LIMB_INDEX_BITS-1:0] nlimbs_q, nlimbs_d;
    logic [ITER_BITS-1:0]       iter_q, iter_d;
    logic [ITER_BITS-1:0]       res_q, res_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            nlimbs_q <= '0;
            iter_q   <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nlimbs_q <= nlimbs_d;
            iter_q   <= iter_d;
            res_q    <= res_d;
        end
    end

    // Job fields and the captured result are exposed straight from their
    // registers; everything else is a decode of the current state.
    assign num_limbs_data    = nlimbs_q;
    assign iter_lim_data     = iter_q;
    assign result_iterations = res_q;
    assign busy              = (state_q != IDLE);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        nlimbs_d        = nlimbs_q;
        iter_d          = iter_q;
        res_d           = res_q;
        job_ready       = 1'b0;
        in_ready        = 1'b0;
        solver_reset    = 1'b0;
        wr_real_en      = 1'b0;
        wr_imag_en      = 1'b0;
        wr_index        = '0;
        real_data       = '0;
        imag_data       = '0;
        wr_num_limbs_en = 1'b0;
        wr_iter_lim_en  = 1'b0;
        start           = 1'b0;
        result_valid    = 1'b0;

        unique case (state_q)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    nlimbs_d = job_num_limbs;
                    iter_d   = job_iter_lim;
                    cnt_d    = '0;
                    state_d  = SRST;
                end
            end
            SRST: begin
                solver_reset = 1'b1;
                state_d      = CFG;
            end
            CFG: begin
                wr_num_limbs_en = 1'b1;
                wr_iter_lim_en  = 1'b1;
                // An empty operand has nothing to stream.
                state_d = (nlimbs_q == '0) ? START : LOAD;
            end
            LOAD: begin
                in_ready   = 1'b1;
                wr_real_en = in_valid;
                wr_imag_en = in_valid;
                wr_index   = cnt_q;
                real_data  = in_real;
                imag_data  = in_imag;
                if (in_valid) begin
                    cnt_d = cnt_q + ONE_IDX;
                    if (cnt_q == nlimbs_q - ONE_IDX) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                start   = 1'b1;
                state_d = GAP;
            end
            // The solver may still show a stale done flag right after start.
            GAP: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (solver_out_ready) begin
                    res_d   = solver_iterations;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_solver_loader.sv
// Directed bench for solver_loader: reset state, streamed jobs with and
// without stalls, empty job, held result, back-to-back jobs and a reset
// that lands in the middle of limb loading.
module tb_solver_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        job_valid;
    logic        job_ready;
    logic [5:0]  job_num_limbs;
    logic [15:0] job_iter_lim;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_real;
    logic [7:0]  in_imag;
    logic        solver_reset;
    logic        wr_real_en;
    logic        wr_imag_en;
    logic [5:0]  wr_index;
    logic [7:0]  real_data;
    logic [7:0]  imag_data;
    logic        wr_num_limbs_en;
    logic [5:0]  num_limbs_data;
    logic        wr_iter_lim_en;
    logic [15:0] iter_lim_data;
    logic        start;
    logic        solver_out_ready;
    logic [15:0] solver_iterations;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] result_iterations;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cnt = 0;
    int srst_cnt = 0;

    logic [7:0] lr [4];
    logic [7:0] li [4];

    solver_loader dut (
        .clock            (clock),
        .reset            (reset),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_num_limbs    (job_num_limbs),
        .job_iter_lim     (job_iter_lim),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_real          (in_real),
        .in_imag          (in_imag),
        .solver_reset     (solver_reset),
        .wr_real_en       (wr_real_en),
        .wr_imag_en       (wr_imag_en),
        .wr_index         (wr_index),
        .real_data        (real_data),
        .imag_data        (imag_data),
        .wr_num_limbs_en  (wr_num_limbs_en),
        .num_limbs_data   (num_limbs_data),
        .wr_iter_lim_en   (wr_iter_lim_en),
        .iter_lim_data    (iter_lim_data),
        .start            (start),
        .solver_out_ready (solver_out_ready),
        .solver_iterations(solver_iterations),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_iterations(result_iterations),
        .busy             (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (start)        start_cnt <= start_cnt + 1;
        if (solver_reset) srst_cnt  <= srst_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one complete job from IDLE back to IDLE. stall_at < 0 means no stall.
    task automatic do_job(input int n, input int iter, input int stall_at, input int stall_len,
                          input logic [15:0] scount, input int rr_delay);
        int t_acc;
        int stall;
        stall = (stall_at >= 0 && stall_at < n) ? stall_len : 0;

        job_valid = 1'b1; job_num_limbs = n[5:0]; job_iter_lim = iter[15:0]; #1;
        chk("idle_job_ready", 32'(job_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        tick();
        t_acc = cyc - 1;
        // Limb data offered early must not be written.
        job_valid = 1'b0; job_num_limbs = 6'h3F; job_iter_lim = 16'hFFFF;
        in_valid = 1'b1; in_real = 8'hEE; in_imag = 8'hDD; #1;
        chk("srst_pulse", 32'(solver_reset), 1);
        chk("srst_job_ready", 32'(job_ready), 0);
        chk("srst_in_ready", 32'(in_ready), 0);
        chk("srst_wr_real", 32'(wr_real_en), 0);
        chk("srst_busy", 32'(busy), 1);
        tick();
        chk("cfg_wr_nl", 32'(wr_num_limbs_en), 1);
        chk("cfg_wr_il", 32'(wr_iter_lim_en), 1);
        chk("cfg_nl_data", 32'(num_limbs_data), n);
        chk("cfg_il_data", 32'(iter_lim_data), iter);
        chk("cfg_in_ready", 32'(in_ready), 0);
        chk("cfg_srst", 32'(solver_reset), 0);
        tick();
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    in_valid = 1'b0; in_real = 8'hFF; in_imag = 8'hFF; #1;
                    chk("stall_wr_real", 32'(wr_real_en), 0);
                    chk("stall_wr_imag", 32'(wr_imag_en), 0);
                    chk("stall_index", 32'(wr_index), i);
                    chk("stall_in_ready", 32'(in_ready), 1);
                    tick();
                end
            end
            in_valid = 1'b1; in_real = lr[i]; in_imag = li[i]; #1;
            chk("load_wr_real", 32'(wr_real_en), 1);
            chk("load_wr_imag", 32'(wr_imag_en), 1);
            chk("load_index", 32'(wr_index), i);
            chk("load_real", 32'(real_data), 32'(lr[i]));
            chk("load_imag", 32'(imag_data), 32'(li[i]));
            tick();
        end
        in_valid = 1'b1; in_real = 8'h11; in_imag = 8'h22; #1;
        chk("start_pulse", 32'(start), 1);
        chk("start_latency", cyc - t_acc, 3 + n + stall);
        chk("start_in_ready", 32'(in_ready), 0);
        chk("start_wr_real", 32'(wr_real_en), 0);
        tick();
        // A done flag during GAP must be ignored.
        in_valid = 1'b0; solver_out_ready = 1'b1; solver_iterations = ~scount; #1;
        chk("gap_start", 32'(start), 0);
        chk("gap_result_valid", 32'(result_valid), 0);
        tick();
        solver_out_ready = 1'b0; #1;
        chk("wait_result_valid", 32'(result_valid), 0);
        chk("wait_busy", 32'(busy), 1);
        tick();
        solver_out_ready = 1'b1; solver_iterations = scount;
        tick();
        solver_out_ready = 1'b0; solver_iterations = ~scount; #1;
        for (int r = 0; r < rr_delay; r++) begin
            chk("hold_result_valid", 32'(result_valid), 1);
            chk("hold_result_iter", 32'(result_iterations), 32'(scount));
            chk("hold_job_ready", 32'(job_ready), 0);
            tick();
        end
        result_ready = 1'b1; #1;
        chk("result_valid", 32'(result_valid), 1);
        chk("result_iter", 32'(result_iterations), 32'(scount));
        chk("result_job_ready", 32'(job_ready), 0);
        tick();
        result_ready = 1'b0; #1;
        chk("done_job_ready", 32'(job_ready), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_result_valid", 32'(result_valid), 0);
        chk("done_result_iter", 32'(result_iterations), 32'(scount));
    endtask

    initial begin
        int s0;
        int st0;
        reset = 1'b0;
        job_valid = 1'b0; job_num_limbs = '0; job_iter_lim = '0;
        in_valid = 1'b0; in_real = '0; in_imag = '0;
        solver_out_ready = 1'b0; solver_iterations = '0; result_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_job_ready", 32'(job_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_srst", 32'(solver_reset), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_result_iter", 32'(result_iterations), 0);
        chk("rst_nl_data", 32'(num_limbs_data), 0);
        chk("rst_il_data", 32'(iter_lim_data), 0);
        reset = 1'b1;
        tick();

        // Three limbs, no stalls.
        lr[0] = 8'd0; lr[1] = 8'd128; lr[2] = 8'd0; lr[3] = 8'd0;
        li[0] = 8'd0; li[1] = 8'd128; li[2] = 8'd0; li[3] = 8'd0;
        do_job(3, 10, -1, 0, 16'd37, 0);

        // Same job with a two-cycle gap before limb 1.
        do_job(3, 10, 1, 2, 16'd41, 0);

        // Empty operand goes straight from CFG to START.
        do_job(0, 5, -1, 0, 16'd3, 0);

        // Consumer holds off the result for five cycles.
        lr[0] = 8'h5A; li[0] = 8'hA5; lr[1] = 8'hC3; li[1] = 8'h3C;
        do_job(2, 100, -1, 0, 16'hBEEF, 5);

        // Four identical back-to-back jobs.
        lr[0] = 8'd0; lr[1] = 8'd128; lr[2] = 8'd0;
        li[0] = 8'd0; li[1] = 8'd128; li[2] = 8'd0;
        s0 = srst_cnt;
        for (int j = 0; j < 4; j++) begin
            do_job(3, 10, -1, 0, 16'd77, 0);
        end
        chk("b2b_srst_count", srst_cnt - s0, 4);

        // Reset while loading limb 1.
        job_valid = 1'b1; job_num_limbs = 6'd3; job_iter_lim = 16'd10;
        tick();
        job_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1; in_real = lr[0]; in_imag = li[0];
        tick();
        in_real = lr[1]; in_imag = li[1]; #1;
        chk("mid_index", 32'(wr_index), 1);
        chk("mid_wr_real", 32'(wr_real_en), 1);
        st0 = start_cnt;
        reset = 1'b0; #1;
        chk("arst_job_ready", 32'(job_ready), 1);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_wr_real", 32'(wr_real_en), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_index", 32'(wr_index), 0);
        chk("arst_real", 32'(real_data), 0);
        chk("arst_nl_data", 32'(num_limbs_data), 0);
        chk("arst_il_data", 32'(iter_lim_data), 0);
        chk("arst_result_iter", 32'(result_iterations), 0);
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_job_ready", 32'(job_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);
        repeat (3) tick();
        chk("post_rst_no_start", start_cnt - st0, 0);

        // Fresh job after the abandoned one.
        do_job(3, 10, -1, 0, 16'd55, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
